uart_tx_arbiter: RTL

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_arb_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and default sizing for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    typedef enum logic [1:0] {
        ST_IDLE          = 2'd0,
        ST_WAIT_BUSY     = 2'd1,
        ST_WAIT_NOT_BUSY = 2'd2
    } state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester after owner_i wins.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int OWNER_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible_i,
    input  logic [OWNER_W-1:0] owner_i,
    output logic [OWNER_W-1:0] winner_o,
    output logic               valid_o
);

    logic [OWNER_W-1:0] idx_s;
    logic               hit_s;

    // Walk owner+1 .. owner+NUM_REQ (mod NUM_REQ); the current owner is tried last.
    always_comb begin
        winner_o = owner_i;
        valid_o  = 1'b0;
        idx_s    = '0;
        hit_s    = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx_s    = OWNER_W'((int'(owner_i) + k) % NUM_REQ);
            hit_s    = !valid_o && eligible_i[idx_s];
            winner_o = hit_s ? idx_s : winner_o;
            valid_o  = valid_o | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte sources with round-robin
// arbitration, packet locking and a sticky timeout on a UART that never goes busy.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int OWNER_W        = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     ack,
    output logic [7:0]             data,
    output logic                   dataReady,
    input  logic                   busy,
    output logic [OWNER_W-1:0]     owner,
    output logic                   locked,
    output logic                   timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    state_e             state_q, state_d;
    logic [7:0]         data_q, data_d;
    logic               drdy_q, drdy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    logic [OWNER_W-1:0] owner_q, owner_d;
    logic               locked_q, locked_d;
    logic               terr_q, terr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [NUM_REQ-1:0] own_mask_s;
    logic [NUM_REQ-1:0] elig_s;
    logic [OWNER_W-1:0] win_s;
    logic               win_vld_s;
    logic [7:0]         win_byte_s;

    // While a packet is locked only the owner may be granted.
    always_comb begin
        own_mask_s          = '0;
        own_mask_s[owner_q] = 1'b1;
        elig_s              = locked_q ? (req & own_mask_s) : req;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWNER_W (OWNER_W)
    ) u_rr_pick (
        .eligible_i (elig_s),
        .owner_i    (owner_q),
        .winner_o   (win_s),
        .valid_o    (win_vld_s)
    );

    // Byte multiplexer for the current winner.
    always_comb begin
        win_byte_s = 8'h00;
        for (int i = 0; i < NUM_REQ; i++) begin
            win_byte_s = (win_s == OWNER_W'(i)) ? req_data[8*i +: 8] : win_byte_s;
        end
    end

    // Next-state and output logic; cnt_q holds completed wait cycles, so T-1 marks the T-th.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        drdy_d   = drdy_q;
        ack_d    = '0;
        owner_d  = owner_q;
        locked_d = locked_q;
        terr_d   = terr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld_s) begin
                    data_d       = win_byte_s;
                    drdy_d       = 1'b1;
                    ack_d[win_s] = 1'b1;
                    owner_d      = win_s;
                    locked_d     = ~req_last[win_s];
                    cnt_d        = '0;
                    state_d      = ST_WAIT_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_BUSY: begin
                if (busy) begin
                    drdy_d  = 1'b0;
                    state_d = ST_WAIT_NOT_BUSY;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    drdy_d   = 1'b0;
                    terr_d   = 1'b1;
                    locked_d = 1'b0;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_NOT_BUSY: begin
                if (!busy) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_NOT_BUSY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; owner resets to the last index so requester 0 goes first.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            data_q   <= 8'h00;
            drdy_q   <= 1'b0;
            ack_q    <= '0;
            owner_q  <= OWNER_W'(NUM_REQ - 1);
            locked_q <= 1'b0;
            terr_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            drdy_q   <= drdy_d;
            ack_q    <= ack_d;
            owner_q  <= owner_d;
            locked_q <= locked_d;
            terr_q   <= terr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ack         = ack_q;
    assign data        = data_q;
    assign dataReady   = drdy_q;
    assign owner       = owner_q;
    assign locked      = locked_q;
    assign timeout_err = terr_q;

endmodule
